// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding, default frame width and
// the baud-generator divider constants used by both the generator and the
// receive framer.
package uart_pkg;

    // Default number of data bits per frame (LSB first, no parity).
    localparam int DATA_BITS_DEF = 8;

    // Full-bit divider and half-bit point of the baud generator.
    localparam int BPS_PARA   = 868;
    localparam int BPS_PARA_2 = 434;

    // Receive framer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync_edge.sv
// Brings the asynchronous serial line into the clk domain through two flops,
// keeps one history flop of the synchronised level and produces a registered
// one-cycle pulse on each high-to-low transition of the line.
module uart_rx_sync_edge #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic synced_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;
    logic fall_q;
    logic fall_d;

    // Falling edge: the previous synchronised sample was high, the current one is low.
    assign fall_d = hist_q & ~sync2_q;

    // Synchroniser chain, history flop and registered edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
            hist_q  <= IDLE_LEVEL;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            fall_q  <= fall_d;
        end
    end

    assign synced_o = sync2_q;
    assign fall_o   = fall_q;

endmodule : uart_rx_sync_edge

// File: rtl/uart_rx_frame.sv
// UART receive framer. Detects the start edge, asks the baud generator to run
// (bps_start), samples start/data/stop bits on the mid-bit clk_bps strobes and
// emits each byte with a one-cycle valid strobe, or a one-cycle framing-error
// strobe when the stop bit is sampled low.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int   DATA_BITS  = DATA_BITS_DEF,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rs232_rx,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err
);

    // Counter holds 0..DATA_BITS; DATA leaves before it could wrap.
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic                 synced;
    logic                 fall;

    rx_state_e            state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 bps_start_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;

    uart_rx_sync_edge #(
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_i     (rs232_rx),
        .synced_o (synced),
        .fall_o   (fall)
    );

    // Data arrives LSB first, so new samples enter at the MSB and shift down.
    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign shift_d = synced;
        end else begin : g_shift_many
            assign shift_d = {synced, shift_q[DATA_BITS-1:1]};
        end
    endgenerate

    // Frame state machine with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            bps_start_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // Strobes are single-cycle by default.
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // clk_bps is ignored here; only a start edge wakes the framer.
                    if (fall) begin
                        bps_start_q <= 1'b1;
                        state_q     <= START;
                    end
                end

                START: begin
                    if (clk_bps) begin
                        if (synced) begin
                            // Line is high again at mid start bit: a glitch, not a frame.
                            bps_start_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            bit_cnt_q <= '0;
                            state_q   <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (clk_bps) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (clk_bps) begin
                        if (synced) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            // Keep the last good byte; only flag the error.
                            frame_err_q <= 1'b1;
                        end
                        // Leaving at mid stop bit gives half a bit to re-arm.
                        bps_start_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    bps_start_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bps_start = bps_start_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule : uart_rx_frame

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int BIT_CLK = 869;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rs232_rx;
    logic       clk_bps;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    // Baud generator model paired with the framer.
    logic [15:0] bcnt;
    logic        gen_bps;
    logic        extra_bps;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   last_valid_cyc = -1;
    int   last_gap = 0;
    logic prev_strobe = 1'b0;
    logic [7:0] last_good = 8'h00;

    always #10 clk = ~clk;

    uart_rx_frame #(
        .DATA_BITS  (8),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs232_rx  (rs232_rx),
        .clk_bps   (clk_bps),
        .bps_start (bps_start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt    <= '0;
            gen_bps <= 1'b0;
        end else begin
            if (!bps_start || bcnt == 16'(BPS_PARA)) bcnt <= '0;
            else bcnt <= bcnt + 16'd1;
            gen_bps <= bps_start && (bcnt == 16'(BPS_PARA_2));
        end
    end

    assign clk_bps = gen_bps | extra_bps;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: pop one expectation per strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rx_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {30'd0, rx_valid, frame_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind_err", frame_err, e.err);
                    check(e.err ? "rx_data_hold" : "rx_data", rx_data, e.data);
                    $display("[%0t] rx strobe valid=%0b err=%0b data=%02h", $time, rx_valid, frame_err, rx_data);
                end
                check("valid_err_exclusive", rx_valid & frame_err, 0);
                check("no_consecutive_strobe", prev_strobe, 0);
                check("bps_start_low_at_strobe", bps_start, 0);
                if (rx_valid) begin
                    if (last_valid_cyc >= 0) last_gap = cyc - last_valid_cyc;
                    last_valid_cyc = cyc;
                end
            end
            prev_strobe = rx_valid | frame_err;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    task automatic drive_bit(input logic b);
        rs232_rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic push_good(input logic [7:0] d);
        exp_t e;
        e.err = 1'b0;
        e.data = d;
        exp_q.push_back(e);
        last_good = d;
    endtask

    task automatic push_err();
        exp_t e;
        e.err = 1'b1;
        e.data = last_good;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int hi_cnt;
        rst_n     = 1'b0;
        rs232_rx  = 1'b1;
        extra_bps = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_bps_start", bps_start, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // clk_bps pulses on an idle line must be ignored.
        for (int k = 0; k < 3; k++) begin
            extra_bps = 1'b1;
            @(negedge clk);
            extra_bps = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("idle_bps_ignored", bps_start, 0);

        // Single frame 0x55.
        push_good(8'h55);
        send_frame(8'h55, 1'b1);
        wait_drain("drain_55");
        check("final_rx_data_55", rx_data, 8'h55);
        check("bps_start_idle_55", bps_start, 0);

        // Back-to-back frames, no idle gap.
        push_good(8'hA3);
        push_good(8'h0F);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_drain("drain_b2b");
        check("b2b_gap_ok", (last_gap >= 8685 && last_gap <= 8695), 1);

        // 200-clk glitch on an idle line.
        repeat (50) @(negedge clk);
        lat = -1;
        hi_cnt = 0;
        rs232_rx = 1'b0;
        for (int i = 1; i <= 1500; i++) begin
            if (i == 200) rs232_rx = 1'b1;
            @(negedge clk);
            if (bps_start) begin
                hi_cnt++;
                if (lat < 0) lat = i;
            end
        end
        check("start_edge_latency_ok", (lat >= 3 && lat <= 5), 1);
        check("glitch_bps_high_len_ok", (hi_cnt >= 430 && hi_cnt <= 445), 1);
        check("glitch_bps_start_low", bps_start, 0);
        check("glitch_rx_data_kept", rx_data, 8'h0F);

        // Framing error followed by a held break.
        push_err();
        send_frame(8'hFF, 1'b0);
        wait_drain("drain_err");
        repeat (5000) @(negedge clk);
        check("break_bps_start_low", bps_start, 0);
        check("break_rx_data_kept", rx_data, 8'h0F);
        rs232_rx = 1'b1;
        repeat (2000) @(negedge clk);
        push_good(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_drain("drain_5a");

        // Reset during data bit 4 of 0x3C.
        repeat (100) @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(((8'h3C >> i) & 8'h01) != 0);
        rs232_rx = 1'b1;
        repeat (400) @(negedge clk);
        check("midframe_bps_start_high", bps_start, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_bps_start", bps_start, 0);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_frame_err", frame_err, 0);
        last_good = 8'h00;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        check("post_rst_no_strobe_q", exp_q.size(), 0);
        push_good(8'hC3);
        send_frame(8'hC3, 1'b1);
        wait_drain("drain_c3");
        check("final_rx_data_c3", rx_data, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_uart_rx_frame

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receive framer that sits directly downstream of the baud-rate generator.
- Detects the start bit on the serial line and raises bps_start so the generator begins counting.
- Consumes the mid-bit clk_bps strobes to sample the start bit, the data bits (LSB first) and the stop bit.
- Presents each received byte with a one-cycle valid strobe to the RAM-write logic, and flags framing errors.

Parameters:
DATA_BITS, 8, number of data bits per frame (LSB first; no parity)
IDLE_LEVEL, 1'b1, serial line idle level; also the reset value of the synchroniser flops

Ports:
clk  input  1  50 MHz system clock
rst_n  input  1  asynchronous active-low reset
rs232_rx  input  1  asynchronous serial receive line
clk_bps  input  1  one-cycle mid-bit strobe from the baud generator
bps_start  output  1  held high while a frame is in progress; low resets the baud counter
rx_data  output  DATA_BITS  last received byte; holds its value until the next good frame
rx_valid  output  1  one-cycle strobe; rx_data is valid in the same cycle
frame_err  output  1  one-cycle strobe; stop bit was sampled low

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n. All flops reset asynchronously on rst_n low.
- Reset values:
  - bps_start=0, rx_data=0, rx_valid=0, frame_err=0.
  - State=IDLE, bit counter=0.
  - Synchroniser and edge-history flops = IDLE_LEVEL.
- Input path:
  - rs232_rx passes through 2 synchroniser flops, then 1 history flop.
  - fall = history & ~synced.
  - Start-edge detection latency: 3 clk from a pin change to the fall pulse.
- State machine:
  - IDLE: bps_start=0. On fall go to START and set bps_start=1 on the next edge. Any fall seen outside IDLE is ignored.
  - START: on clk_bps, sample synced. If 1 (glitch/false start): bps_start<=0, go to IDLE, no strobes. If 0: bit counter<=0, go to DATA.
  - DATA: on each clk_bps, shift_reg <= {synced, shift_reg[DATA_BITS-1:1]} and increment the counter. After the DATA_BITS-th sample go to STOP.
  - STOP: on clk_bps:
    - If synced=1: rx_data<=shift_reg and rx_valid=1 for exactly one cycle.
    - Else: frame_err=1 for one cycle and rx_data is left unchanged.
    - In both cases bps_start<=0 and go to IDLE.
- Timing (BPS_PARA=868, BPS_PARA_2=434):
  - The first clk_bps arrives 436 clk after bps_start rises, i.e. near the start-bit centre.
  - Subsequent strobes arrive every 869 clk.
- Returning to IDLE at mid-stop-bit leaves half a bit to re-arm for back-to-back frames.
- Break condition (line held low): a framing error is reported once. The block re-arms only after the line returns high and a new falling edge occurs.
- rx_valid and frame_err are mutually exclusive and never high in consecutive cycles.
- clk_bps asserted while in IDLE is ignored.
- Reset mid-frame: the frame is abandoned, outputs return to reset values, and no strobe is generated.
- Counter width: $clog2(DATA_BITS+1). Wrap cannot occur because DATA exits at DATA_BITS.

Decomposition:
- uart_pkg holds:
  - rx state enum {IDLE, START, DATA, STOP}
  - DATA_BITS default
  - BPS_PARA / BPS_PARA_2 constants, shared with the baud generator
- One sub-module: uart_rx_sync_edge. It contains the 2-flop synchroniser and the falling-edge detector and outputs synced and fall.

Test Plan:
- Bench pairs the block with the baud generator at 868/434; the line is driven at 869 clk per bit.
- Byte 0x55 → rx_valid pulses once; rx_data=0x55; frame_err=0; bps_start returns to 0 within 1 clk of the stop-bit strobe.
- Back-to-back frames 0xA3 then 0x0F with no idle gap → two rx_valid pulses ~8690 clk apart carrying 0xA3 and 0x0F.
- 200-clk low glitch on an idle line → START samples 1 and returns to IDLE; no rx_valid, no frame_err; bps_start high for ~437 clk.
- Frame 0xFF with stop bit driven 0 → frame_err pulses once, rx_valid stays 0, rx_data keeps its prior value; a held break produces no further strobes until the line goes high and then low.
- rst_n asserted during data bit 4 of 0x3C → all outputs go to 0 immediately. A following clean 0xC3 frame is received correctly.
